// File: rtl/modexp_pkg.sv
// Shared types and default sizing for the modular-exponentiation sequencer.
package modexp_pkg;

  localparam int unsigned W_DEF  = 3;
  localparam int unsigned EW_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR_REQ,
    S_SQR_WAIT,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod modulus
// by driving an external serial modular multiplier over mm_* handshakes.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned EW = EW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exp,
  input  logic [W-1:0]  modulus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic          mm_start,
  output logic [W-1:0]  mm_x,
  output logic [W-1:0]  mm_y,
  output logic [W-1:0]  mm_z,
  input  logic          mm_done,
  input  logic [W-1:0]  mm_p
);

  localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;

  state_t        state;
  logic [W-1:0]  acc;
  logic [W-1:0]  base_r;
  logic [W-1:0]  mod_r;
  logic [EW-1:0] exp_r;
  logic [IW-1:0] i;

  // Outputs are registered, so every request/result is loaded on the edge
  // that enters the corresponding state; acc and the next operands both
  // take mm_p directly on the mm_done edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      mm_start <= 1'b0;
      mm_x     <= '0;
      mm_y     <= '0;
      mm_z     <= '0;
      acc      <= '0;
      i        <= '0;
      base_r   <= '0;
      mod_r    <= '0;
      exp_r    <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_r <= base;
            exp_r  <= exp;
            mod_r  <= modulus;
            acc    <= W'(1);
            i      <= IW'(EW - 1);
            busy   <= 1'b1;
            err    <= 1'b0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (mod_r < W'(2)) begin
            result <= '0;
            err    <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (base_r >= mod_r) begin
            result <= '0;
            err    <= 1'b1;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            mm_x     <= acc;
            mm_y     <= acc;
            mm_z     <= mod_r;
            mm_start <= 1'b1;
            state    <= S_SQR_REQ;
          end
        end
        S_SQR_REQ: state <= S_SQR_WAIT;
        S_SQR_WAIT: begin
          if (mm_done) begin
            acc <= mm_p;
            if (exp_r[i]) begin
              mm_x     <= mm_p;
              mm_y     <= base_r;
              mm_start <= 1'b1;
              state    <= S_MUL_REQ;
            end else if (i == '0) begin
              result <= mm_p;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              i        <= i - IW'(1);
              mm_x     <= mm_p;
              mm_y     <= mm_p;
              mm_start <= 1'b1;
              state    <= S_SQR_REQ;
            end
          end
        end
        S_MUL_REQ: state <= S_MUL_WAIT;
        S_MUL_WAIT: begin
          if (mm_done) begin
            acc <= mm_p;
            if (i == '0) begin
              result <= mm_p;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              i        <= i - IW'(1);
              mm_x     <= mm_p;
              mm_y     <= mm_p;
              mm_start <= 1'b1;
              state    <= S_SQR_REQ;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a behavioural variable-latency
// multiplier and a plain-arithmetic modexp reference model.
module tb_modexp_ctrl;

  localparam int unsigned W  = 3;
  localparam int unsigned EW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exp;
  logic [W-1:0]  modulus;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic          mm_start;
  logic [W-1:0]  mm_x, mm_y, mm_z;
  logic          mm_done;
  logic [W-1:0]  mm_p;

  modexp_ctrl #(.W(W), .EW(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exp(exp),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result),
    .mm_start(mm_start), .mm_x(mm_x), .mm_y(mm_y), .mm_z(mm_z),
    .mm_done(mm_done), .mm_p(mm_p)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int Lcur  = 1;
  bit spur_en = 1'b0;

  typedef struct {int res; int err; int n; int k; int L;} exp_t;
  typedef struct {int x; int y; int z; bit sq;} op_t;
  exp_t sbq[$];
  op_t  opq[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: square-and-multiply on integers, recording every multiply.
  task automatic push_expect(int b, int e, int m, int k);
    exp_t r;
    int a;
    r.k = k; r.L = Lcur; r.n = 0; r.res = 0; r.err = 0;
    if (m < 2) begin
      r.err = 0;
    end else if (b >= m) begin
      r.err = 1;
    end else begin
      a = 1;
      for (int j = EW - 1; j >= 0; j--) begin
        opq.push_back('{a, a, m, 1'b1});
        a = (a * a) % m;
        r.n++;
        if (((e >> j) & 1) == 1) begin
          opq.push_back('{a, b, m, 1'b0});
          a = (a * b) % m;
          r.n++;
        end
      end
      r.res = a;
    end
    sbq.push_back(r);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    sbq.delete();
    opq.delete();
  endtask

  task automatic issue(int b, int e, int m);
    @(posedge clk);
    #1;
    base    = W'(b);
    exp     = EW'(e);
    modulus = W'(m);
    start   = 1'b1;
    push_expect(b, e, m, cyc);
  endtask

  task automatic finish_op(bit hold);
    bit got;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    base    = W'($urandom);
    exp     = EW'($urandom);
    modulus = W'($urandom);
    got = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) begin
      check("done_timeout", 0, 1);
      do_reset(3);
    end
  endtask

  task automatic run(int b, int e, int m, bit hold);
    issue(b, e, m);
    finish_op(hold);
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  initial begin
    int cnt;
    bit prev;
    exp_t e;
    cnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        prev = 1'b0;
      end else begin
        if (mm_start) begin
          check("mm_start_gap", int'(prev), 0);
          cnt++;
        end
        prev = mm_start;
        if (done) begin
          check("sb_nonempty", int'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("result", int'(result), e.res);
            check("err", int'(err), e.err);
            check("latency", cyc - e.k, 2 + e.n * (e.L + 1));
            check("mm_start_count", cnt, e.n);
            check("busy_at_done", int'(busy), 1);
          end
          cnt = 0;
        end
      end
    end
  end

  // Behavioural multiplier with latency Lcur; optionally injects a stray
  // mm_done while the controller sits in a square request.
  initial begin
    op_t o;
    int cx, cy, cz, p, L;
    mm_done = 1'b0;
    mm_p    = '0;
    forever begin
      @(negedge clk);
      if (!reset && mm_start) begin
        cx = int'(mm_x); cy = int'(mm_y); cz = int'(mm_z); L = Lcur;
        o = '{0, 0, 0, 1'b0};
        check("op_queue", int'(opq.size() > 0), 1);
        if (opq.size() > 0) begin
          o = opq.pop_front();
          check("mm_x", cx, o.x);
          check("mm_y", cy, o.y);
          check("mm_z", cz, o.z);
        end
        p = (cz == 0) ? 0 : (cx * cy) % cz;
        if (spur_en && o.sq) begin
          mm_done = 1'b1;
          mm_p    = W'($urandom);
        end
        for (int q = 0; q < L; q++) begin
          @(posedge clk);
          #1 mm_done = 1'b0;
        end
        if (busy) begin
          check("mm_x_stable", int'(mm_x), cx);
          check("mm_y_stable", int'(mm_y), cy);
          check("mm_z_stable", int'(mm_z), cz);
        end
        mm_done = 1'b1;
        mm_p    = W'(p);
        @(posedge clk);
        #1 mm_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int b, e, m;
    bit hold;
    reset = 1'b1; start = 1'b0; base = '0; exp = '0; modulus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_result", int'(result), 0);
    check("rst_mm_start", int'(mm_start), 0);
    check("rst_mm_x", int'(mm_x), 0);
    check("rst_mm_y", int'(mm_y), 0);
    check("rst_mm_z", int'(mm_z), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    Lcur = 3; run(3, 5, 7, 1'b0);
    Lcur = 2; run(2, 15, 7, 1'b0);
    Lcur = 2; run(0, 3, 1, 1'b0);
    run(7, 9, 5, 1'b0);
    run(5, 2, 5, 1'b1);
    Lcur = 1; run(5, 0, 6, 1'b0);

    // Reset while in the first MUL_WAIT (L=4: MUL_WAIT spans k+8..k+11).
    Lcur = 4;
    issue(3, 8, 7);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_mm_start", int'(mm_start), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_err", int'(err), 0);
    sbq.delete();
    opq.delete();
    repeat (8) @(posedge clk);
    Lcur = 3; run(3, 8, 7, 1'b0);

    Lcur = 5; spur_en = 1'b1; run(6, 11, 7, 1'b1);
    spur_en = 1'b0;

    for (int it = 0; it < 40; it++) begin
      Lcur    = int'($urandom_range(1, 8));
      hold    = bit'($urandom_range(0, 1));
      spur_en = bit'($urandom_range(0, 1));
      m = int'($urandom_range(0, 7));
      if (m > 1 && $urandom_range(0, 3) != 0) b = int'($urandom_range(0, m - 1));
      else b = int'($urandom_range(0, 7));
      e = int'($urandom_range(0, 15));
      run(b, e, m, hold);
    end
    spur_en = 1'b0;

    repeat (12) @(posedge clk);
    check("sb_drained", sbq.size(), 0);
    check("ops_drained", opq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencer that computes base^exp mod modulus by driving a shared serial modular multiplier through a start/done handshake. It runs left-to-right square-and-multiply over a fixed-width exponent and validates operands. It sits above the interleaved modular multiplier and owns that multiplier exclusively while busy.

## Interface
Parameters:
- W, 3, operand/modulus/result width
- EW, 4, exponent width (number of squaring steps)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- base  in  W  operand, latched at start
- exp  in  EW  exponent, latched at start
- modulus  in  W  modulus, latched at start
- busy  out  1  high from the cycle after accepted start through DONE
- done  out  1  one-cycle pulse, result/err valid
- err  out  1  operand error, valid with done, held until next start
- result  out  W  final value, held until next accepted start
- mm_start  out  1  one-cycle pulse, multiply request
- mm_x, mm_y, mm_z  out  W  multiplicand, multiplier, modulus; stable from mm_start until mm_done
- mm_done  in  1  one-cycle pulse from multiplier
- mm_p  in  W  product mod mm_z, valid with mm_done

## Operation
- Reset values: busy 0, done 0, err 0, result 0, mm_start 0, mm_x/mm_y/mm_z 0, state IDLE, acc 0, bit index 0.
- IDLE: on start, latch base/exp/modulus, acc ← 1, i ← EW-1 → CHECK. start in any other state is ignored.
- CHECK:
  - modulus < 2 → result 0, err 0 → DONE.
  - base ≥ modulus → result 0, err 1 → DONE.
  - Otherwise → SQR_REQ.
- SQR_REQ: mm_x = mm_y = acc, mm_z = modulus, mm_start = 1 → SQR_WAIT.
- SQR_WAIT: on mm_done, acc ← mm_p.
  - exp[i] = 1 → MUL_REQ.
  - else i = 0 → DONE.
  - else i ← i-1 → SQR_REQ.
- MUL_REQ: mm_x = acc, mm_y = base, mm_z = modulus, mm_start = 1 → MUL_WAIT.
- MUL_WAIT: on mm_done, acc ← mm_p.
  - i = 0 → DONE.
  - else i ← i-1 → SQR_REQ.
- DONE: result ← acc (non-error path), done = 1 → IDLE.
- Arithmetic:
  - acc is W bits. The multiplier's operand precondition (x, y < z) holds by construction because acc < modulus and base < modulus.
  - exp = 0 still performs EW squarings of 1, giving result 1.
- mm_done outside SQR_WAIT/MUL_WAIT is ignored. mm_p is sampled only on mm_done.
- Reset mid-operation: immediate return to IDLE with reset values. The multiplier shares the same reset, so no stale mm_done is expected. Any that arrives is ignored.

## Timing
- Start accepted at edge k: CHECK in cycle k+1. busy rises at k+1.
- Multiplier latency L ≥ 1: mm_start in cycle c, mm_done in cycle c+L.
- n = EW + popcount(exp) multiplications. Each costs L+1 cycles (REQ plus L WAIT cycles).
- done at cycle k+2+n(L+1). Error or modulus < 2 cases: done at k+2, with no mm_start.
- busy falls in the cycle after DONE. A new start is accepted in that IDLE cycle.
- Exactly n mm_start pulses per operation. mm_start is never high in two consecutive cycles.

## Structure
- Shared package modexp_pkg:
  - state enumeration (IDLE, CHECK, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE)
  - default W/EW constants
- Natural sub-module: modmul_serial, the interleaved shift-add-subtract modular multiplier with start/done/p ports matching mm_*. It is instantiated beside modexp_ctrl in the top-level wrapper, not inside it.
- Controller is one FSM plus datapath registers (acc, i, latched operands). No internal arithmetic beyond compares.

## Test plan
- base=3, exp=4'b0101, modulus=7, L=3 → result 5, err 0; 6 mm_start pulses; done exactly 2+6·4=26 cycles after start.
- base=2, exp=4'b1111, modulus=7 → result 1; 8 multiplications; operand sequence squares/multiplies alternates per bit.
- base=5, exp=0, modulus=6 → result 1; 4 squarings of acc=1, no MUL_REQ.
- modulus=1 (result 0, err 0) and base=7/modulus=5 (result 0, err 1) → done at start+2, no mm_start.
- reset asserted in MUL_WAIT → next cycle busy 0, done 0, mm_start 0, result 0. Fresh start then completes correctly.
- start held high during busy, plus spurious mm_done in SQR_REQ → ignored. Result matches the single-operation reference. Repeat with randomized L in 1..8 against a behavioural modexp model.
